// File: rtl/billiard_pkg.sv
// Shared billiard types: ball/hole identifiers, pocket FSM states and a
// lowest-set-hole priority helper used by the overlap bookkeeping.
package billiard_pkg;

  localparam int MAX_BALLS = 16;
  localparam int MAX_HOLES = 8;

  typedef logic [$clog2(MAX_BALLS)-1:0] ball_id_t;  // 4 bits
  typedef logic [$clog2(MAX_HOLES)-1:0] hole_id_t;  // 3 bits

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_REPORT = 2'd2
  } pocket_state_t;

  // Index of the lowest set bit of a hole request vector (0 when none set).
  function automatic hole_id_t lowest_hole(input logic [MAX_HOLES-1:0] req);
    hole_id_t id;
    id = '0;
    for (int h = MAX_HOLES - 1; h >= 0; h--) begin
      if (req[h]) begin
        id = hole_id_t'(h);
      end else begin
        id = id;
      end
    end
    return id;
  endfunction

endpackage

// File: rtl/overlap_counter.sv
// Per-ball overlap bookkeeping: a saturating live pixel counter with a
// first-hole latch, plus shadow copies taken at the frame snapshot.
module overlap_counter
  import billiard_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sof_i,          // frame start: live state restarts
  input  logic             snap_i,         // frame start accepted: copy to shadow
  input  logic             hit_i,          // this ball overlaps some hole now
  input  hole_id_t         hole_i,         // lowest overlapping hole this pixel
  output logic [CNT_W-1:0] shadow_cnt_o,
  output hole_id_t         shadow_hole_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] live_cnt_q, live_cnt_d;
  hole_id_t         live_hole_q, live_hole_d;
  logic [CNT_W-1:0] shadow_cnt_q, shadow_cnt_d;
  hole_id_t         shadow_hole_q, shadow_hole_d;

  // Next-state for the live counter, hole latch and shadow copy.
  always_comb begin
    live_cnt_d    = live_cnt_q;
    live_hole_d   = live_hole_q;
    shadow_cnt_d  = shadow_cnt_q;
    shadow_hole_d = shadow_hole_q;

    if (snap_i) begin
      shadow_cnt_d  = live_cnt_q;
      shadow_hole_d = live_hole_q;
    end else begin
      shadow_cnt_d  = shadow_cnt_q;
      shadow_hole_d = shadow_hole_q;
    end

    if (sof_i) begin
      // An overlap on the frame-start pixel already belongs to the new frame.
      if (hit_i) begin
        live_cnt_d  = CNT_ONE;
        live_hole_d = hole_i;
      end else begin
        live_cnt_d  = '0;
        live_hole_d = '0;
      end
    end else if (hit_i) begin
      // A zero count means this is the first overlap of the frame.
      if (live_cnt_q == '0) begin
        live_hole_d = hole_i;
      end else begin
        live_hole_d = live_hole_q;
      end
      if (live_cnt_q != CNT_MAX) begin
        live_cnt_d = live_cnt_q + CNT_ONE;
      end else begin
        live_cnt_d = live_cnt_q;
      end
    end else begin
      live_cnt_d  = live_cnt_q;
      live_hole_d = live_hole_q;
    end
  end

  // Register bank with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      live_cnt_q    <= '0;
      live_hole_q   <= '0;
      shadow_cnt_q  <= '0;
      shadow_hole_q <= '0;
    end else begin
      live_cnt_q    <= live_cnt_d;
      live_hole_q   <= live_hole_d;
      shadow_cnt_q  <= shadow_cnt_d;
      shadow_hole_q <= shadow_hole_d;
    end
  end

  assign shadow_cnt_o  = shadow_cnt_q;
  assign shadow_hole_o = shadow_hole_q;

endmodule

// File: rtl/pocket_detector.sv
// Pocket detector: accumulates ball/hole overlap per frame, then scans the
// frame's totals and reports each newly pocketed ball over valid/ready.
module pocket_detector
  import billiard_pkg::*;
#(
  parameter int NUM_BALLS = 16,
  parameter int NUM_HOLES = 6,
  parameter int CNT_W     = 8,
  parameter int THRESH    = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic [NUM_BALLS-1:0] ballDrawingRequest,
  input  logic [NUM_HOLES-1:0] holeDrawingRequest,
  input  logic                 pocketReady,
  input  logic [NUM_BALLS-1:0] clearPocketed,
  output logic                 pocketValid,
  output ball_id_t             pocketBallId,
  output hole_id_t             pocketHoleId,
  output logic [NUM_BALLS-1:0] pocketedMask,
  output logic                 frameOverrun
);

  localparam ball_id_t         LAST_IDX = ball_id_t'(NUM_BALLS - 1);
  localparam logic [CNT_W-1:0] THR      = CNT_W'(THRESH);

  logic [MAX_HOLES-1:0] hole_pad_s;
  logic                 any_hole_s;
  hole_id_t             low_hole_s;
  logic                 snap_s;

  logic [CNT_W-1:0] shadow_cnt_s  [NUM_BALLS];
  hole_id_t         shadow_hole_s [NUM_BALLS];

  pocket_state_t        state_q, state_d;
  ball_id_t             idx_q, idx_d;
  logic                 valid_q, valid_d;
  ball_id_t             ball_id_q, ball_id_d;
  hole_id_t             hole_id_q, hole_id_d;
  logic [NUM_BALLS-1:0] mask_q, mask_d;
  logic [NUM_BALLS-1:0] set_mask_s;
  logic                 overrun_q, overrun_d;

  assign hole_pad_s = MAX_HOLES'(holeDrawingRequest);
  assign any_hole_s = |holeDrawingRequest;
  assign low_hole_s = lowest_hole(hole_pad_s);

  for (genvar b = 0; b < NUM_BALLS; b++) begin : g_ball
    overlap_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk          (clk),
      .reset        (reset),
      .sof_i        (startOfFrame),
      .snap_i       (snap_s),
      .hit_i        (ballDrawingRequest[b] & any_hole_s),
      .hole_i       (low_hole_s),
      .shadow_cnt_o (shadow_cnt_s[b]),
      .shadow_hole_o(shadow_hole_s[b])
    );
  end

  // Scan/report FSM next state, handshake outputs and pocketed-mask update.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    ball_id_d  = ball_id_q;
    hole_id_d  = hole_id_q;
    set_mask_s = '0;
    snap_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (startOfFrame) begin
          snap_s  = 1'b1;
          state_d = ST_SCAN;
          idx_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if ((shadow_cnt_s[idx_q] >= THR) && !mask_q[idx_q]) begin
          ball_id_d         = idx_q;
          hole_id_d         = shadow_hole_s[idx_q];
          set_mask_s[idx_q] = 1'b1;
          valid_d           = 1'b1;
          state_d           = ST_REPORT;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      ST_REPORT: begin
        if (valid_q && pocketReady) begin
          valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_SCAN;
          end
        end else begin
          state_d = ST_REPORT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

    // A set in the same cycle as a clear wins.
    mask_d    = (mask_q & ~clearPocketed) | set_mask_s;
    overrun_d = startOfFrame && (state_q != ST_IDLE);
  end

  // FSM and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      ball_id_q <= '0;
      hole_id_q <= '0;
      mask_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      ball_id_q <= ball_id_d;
      hole_id_q <= hole_id_d;
      mask_q    <= mask_d;
      overrun_q <= overrun_d;
    end
  end

  assign pocketValid  = valid_q;
  assign pocketBallId = ball_id_q;
  assign pocketHoleId = hole_id_q;
  assign pocketedMask = mask_q;
  assign frameOverrun = overrun_q;

endmodule
